// File: rtl/r22sdf_reorder_pkg.sv
// rtl/r22sdf_reorder_pkg.sv - shared types, sizes and bit-reverse helper for the FFT output reorder buffer
package r22sdf_reorder_pkg;

  localparam int DATA_RESOLUTION = 16;
  localparam int FFT_LENGTH      = 256;
  localparam int AW              = $clog2(FFT_LENGTH);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
  typedef enum logic {W_IDLE, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_READ} rd_state_e;

  // Reverses the low `width` bits of value; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] full_rev;
    full_rev = {<<{value}};
    return full_rev >> (32 - width);
  endfunction

endpackage

// File: rtl/r22sdf_bank_ram.sv
// rtl/r22sdf_bank_ram.sv - simple dual-port sample bank with registered, enabled read
module r22sdf_bank_ram #(
  parameter int dw = 32,
  parameter int aw = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic          re,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem [2**aw];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/r22sdf_reorder.sv
// rtl/r22sdf_reorder.sv - ping-pong reorder of bit-reversed FFT frames into natural bin order
module r22sdf_reorder
  import r22sdf_reorder_pkg::*;
#(
  parameter int data_resolution = DATA_RESOLUTION,
  parameter int fft_length      = FFT_LENGTH
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       sys_en,
  input  logic                       din_valid,
  input  logic                       din_sof,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       dout_sof,
  output logic                       dout_eof,
  output logic                       overflow,
  output logic                       sof_err
);

  localparam int aw = $clog2(fft_length);
  localparam int dw = 2 * data_resolution;
  localparam logic [aw-1:0] last_addr = aw'(fft_length - 1);

  bank_state_e   bank_st [2];
  wr_state_e     wstate;
  rd_state_e     rstate;
  logic [aw-1:0] wcnt, rcnt;
  logic          wbank, rbank, oldest;

  logic          w_en, w_start, w_restart, w_done, ovf_hit, w_bank;
  logic [aw-1:0] w_addr;
  logic          adv, r_issue, r_start, r_bank;
  logic [aw-1:0] r_addr;

  logic          s1_valid, s1_sof, s1_eof, s1_bank;
  logic [dw-1:0] rdata0, rdata1, s1_data;

  always_comb begin
    w_en      = 1'b0;
    w_start   = 1'b0;
    w_restart = 1'b0;
    w_done    = 1'b0;
    ovf_hit   = 1'b0;
    w_bank    = wbank;
    w_addr    = aw'(bitrev(32'(wcnt), aw));
    if (sys_en && din_valid) begin
      if (wstate == W_IDLE) begin
        if (din_sof) begin
          if (bank_st[0] == EMPTY) begin
            w_start = 1'b1;
            w_bank  = 1'b0;
          end else if (bank_st[1] == EMPTY) begin
            w_start = 1'b1;
            w_bank  = 1'b1;
          end else begin
            ovf_hit = 1'b1;
          end
          w_en   = w_start;
          w_addr = '0;
        end
      end else if (din_sof) begin
        w_restart = 1'b1;
        w_en      = 1'b1;
        w_addr    = '0;
      end else begin
        w_en   = 1'b1;
        w_done = (wcnt == last_addr);
      end
    end
  end

  // A stalled S2 stops the whole read side, so the RAM read also needs adv.
  always_comb begin
    adv     = !dout_valid || dout_ready;
    r_issue = 1'b0;
    r_start = 1'b0;
    r_bank  = rbank;
    r_addr  = rcnt;
    if (sys_en && adv) begin
      if (rstate == R_READ) begin
        r_issue = 1'b1;
      end else if (bank_st[oldest] == FULL) begin
        r_issue = 1'b1;
        r_start = 1'b1;
        r_bank  = oldest;
        r_addr  = '0;
      end else if (bank_st[~oldest] == FULL) begin
        r_issue = 1'b1;
        r_start = 1'b1;
        r_bank  = ~oldest;
        r_addr  = '0;
      end
    end
  end

  r22sdf_bank_ram #(.dw(dw), .aw(aw)) u_bank0 (
    .clk(sys_clk), .we(w_en && !w_bank), .waddr(w_addr), .wdata({din_r, din_i}),
    .re(r_issue && !r_bank), .raddr(r_addr), .rdata(rdata0)
  );

  r22sdf_bank_ram #(.dw(dw), .aw(aw)) u_bank1 (
    .clk(sys_clk), .we(w_en && w_bank), .waddr(w_addr), .wdata({din_r, din_i}),
    .re(r_issue && r_bank), .raddr(r_addr), .rdata(rdata1)
  );

  assign s1_data = s1_bank ? rdata1 : rdata0;

  // Writer and reader never touch the same bank in one cycle, so both update bank_st here.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wstate     <= W_IDLE;
      rstate     <= R_IDLE;
      wcnt       <= '0;
      rcnt       <= '0;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      oldest     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eof     <= 1'b0;
      s1_bank    <= 1'b0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      dout_r     <= '0;
      dout_i     <= '0;
      overflow   <= 1'b0;
      sof_err    <= 1'b0;
    end else if (sys_en) begin
      overflow <= ovf_hit;
      sof_err  <= w_restart;

      if (w_start) begin
        wstate          <= W_FILL;
        wbank           <= w_bank;
        wcnt            <= aw'(1);
        bank_st[w_bank] <= FILLING;
      end else if (w_restart) begin
        wcnt <= aw'(1);
      end else if (w_done) begin
        wstate         <= W_IDLE;
        wcnt           <= '0;
        bank_st[wbank] <= FULL;
        if (bank_st[~wbank] != FULL) oldest <= wbank;
      end else if (w_en) begin
        wcnt <= wcnt + 1'b1;
      end

      if (r_start) begin
        rstate          <= R_READ;
        rbank           <= r_bank;
        rcnt            <= aw'(1);
        bank_st[r_bank] <= DRAINING;
      end else if (r_issue) begin
        if (rcnt == last_addr) begin
          rcnt           <= '0;
          bank_st[rbank] <= EMPTY;
          if (bank_st[~rbank] == FULL) begin
            bank_st[~rbank] <= DRAINING;
            rbank           <= ~rbank;
          end else begin
            rstate <= R_IDLE;
          end
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end

      if (adv) begin
        s1_valid   <= r_issue;
        s1_sof     <= r_issue && (r_addr == '0);
        s1_eof     <= r_issue && (r_addr == last_addr);
        if (r_issue) s1_bank <= r_bank;
        dout_valid <= s1_valid;
        dout_sof   <= s1_valid && s1_sof;
        dout_eof   <= s1_valid && s1_eof;
        if (s1_valid) {dout_r, dout_i} <= s1_data;
      end
    end else begin
      overflow <= 1'b0;
      sof_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r22sdf_reorder.sv
// tb/tb_r22sdf_reorder.sv - directed self-checking bench for r22sdf_reorder
module tb_r22sdf_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        din_valid = 1'b0;
  logic        din_sof = 1'b0;
  logic        dout_ready = 1'b0;
  logic [15:0] din_r = '0;
  logic [15:0] din_i = '0;
  logic        dout_valid, dout_sof, dout_eof, overflow, sof_err;
  logic [15:0] dout_r, dout_i;

  always #5 clk = ~clk;

  r22sdf_reorder dut (
    .sys_clk(clk), .sys_rst(rst), .sys_en(en),
    .din_valid(din_valid), .din_sof(din_sof), .din_r(din_r), .din_i(din_i),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_r(dout_r), .dout_i(dout_i),
    .dout_sof(dout_sof), .dout_eof(dout_eof), .overflow(overflow), .sof_err(sof_err)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [33:0] q_out [$];
  int          q_cyc [$];
  int          ovf_cnt = 0, ovf_cyc = -1, serr_cnt = 0, serr_cyc = -1, hold_err = 0;
  logic        p_hold = 1'b0;
  logic [34:0] p_out = '0;

  // Records accepted outputs, event pulses and any change of a stalled output.
  always @(negedge clk) begin
    if (rst) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold && ({dout_valid, dout_sof, dout_eof, dout_r, dout_i} !== p_out)) hold_err++;
      if (dout_valid && dout_ready) begin
        q_out.push_back({dout_sof, dout_eof, dout_r, dout_i});
        q_cyc.push_back(cyc);
      end
      if (overflow) begin ovf_cnt++; ovf_cyc = cyc; end
      if (sof_err) begin serr_cnt++; serr_cyc = cyc; end
      p_hold = dout_valid && !dout_ready;
      p_out  = {dout_valid, dout_sof, dout_eof, dout_r, dout_i};
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic clear_mon();
    q_out.delete();
    q_cyc.delete();
    ovf_cnt = 0; ovf_cyc = -1; serr_cnt = 0; serr_cyc = -1; hold_err = 0;
  endtask

  task automatic send_frame(input logic [7:0] tag, input int n, output int sof_cyc, output int last_cyc);
    sof_cyc = -1;
    last_cyc = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      din_valid = 1'b1;
      din_sof   = (k == 0);
      din_r     = {tag, rev8(8'(k))};
      din_i     = ~{tag, rev8(8'(k))};
      if (k == 0) sof_cyc = cyc;
      last_cyc = cyc;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    for (int c = 0; c < budget && q_out.size() < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic settle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      din_valid  = 1'($urandom_range(0, 1));
      din_sof    = 1'($urandom_range(0, 1));
      din_r      = 16'($urandom);
      din_i      = 16'($urandom);
      dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      compared++;
      if ({dout_valid, dout_r, dout_i, dout_sof, dout_eof, overflow, sof_err} !== 37'd0) begin
        mismatched++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", c,
                 {dout_valid, dout_r, dout_i, dout_sof, dout_eof, overflow, sof_err});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    din_valid = 1'b0;
    din_sof = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic test_single_frame();
    int s, l;
    logic [33:0] expv;
    clear_mon();
    dout_ready = 1'b1;
    send_frame(8'd0, 256, s, l);
    idle();
    wait_outputs(256, 600);
    settle(20);
    compared++;
    if (q_out.size() !== 256) begin
      mismatched++;
      $display("FAIL single_count: got %0d want 256", q_out.size());
    end
    compared++;
    if (q_cyc.size() == 0 || q_cyc[0] !== l + 3) begin
      mismatched++;
      $display("FAIL single_latency: got cycle %0d want %0d", q_cyc.size() ? q_cyc[0] : -1, l + 3);
    end
    for (int j = 0; j < q_out.size() && j < 256; j++) begin
      expv = {j == 0, j == 255, 8'd0, 8'(j), ~{8'd0, 8'(j)}};
      compared++;
      if (q_out[j] !== expv) begin
        mismatched++;
        $display("FAIL single_data[%0d]: got %h want %h", j, q_out[j], expv);
      end
    end
    compared++;
    if (ovf_cnt !== 0 || serr_cnt !== 0) begin
      mismatched++;
      $display("FAIL single_pulses: got overflow %0d sof_err %0d want 0 0", ovf_cnt, serr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int s, l, gaps;
    logic [7:0] tag;
    logic [33:0] expv;
    clear_mon();
    dout_ready = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(8'(f + 1), 256, s, l);
    idle();
    wait_outputs(1024, 1500);
    settle(20);
    compared++;
    if (q_out.size() !== 1024) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d want 1024", q_out.size());
    end
    gaps = 0;
    for (int j = 1; j < q_cyc.size(); j++) if (q_cyc[j] != q_cyc[j-1] + 1) gaps++;
    compared++;
    if (gaps !== 0) begin
      mismatched++;
      $display("FAIL b2b_gaps: got %0d want 0", gaps);
    end
    for (int j = 0; j < q_out.size() && j < 1024; j++) begin
      tag  = 8'(j / 256 + 1);
      expv = {(j % 256) == 0, (j % 256) == 255, tag, 8'(j % 256), ~{tag, 8'(j % 256)}};
      compared++;
      if (q_out[j] !== expv) begin
        mismatched++;
        $display("FAIL b2b_data[%0d]: got %h want %h", j, q_out[j], expv);
      end
    end
    compared++;
    if (ovf_cnt !== 0) begin
      mismatched++;
      $display("FAIL b2b_overflow: got %0d want 0", ovf_cnt);
    end
  endtask

  task automatic test_stall();
    int s, l;
    logic [7:0] tag;
    logic [33:0] expv;
    clear_mon();
    fork
      begin
        send_frame(8'd5, 256, s, l);
        send_frame(8'd6, 256, s, l);
        idle();
      end
      begin
        for (int c = 0; c < 4000 && q_out.size() < 512; c++) begin
          @(posedge clk); #1;
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    dout_ready = 1'b1;
    settle(20);
    compared++;
    if (q_out.size() !== 512) begin
      mismatched++;
      $display("FAIL stall_count: got %0d want 512", q_out.size());
    end
    for (int j = 0; j < q_out.size() && j < 512; j++) begin
      tag  = (j < 256) ? 8'd5 : 8'd6;
      expv = {(j % 256) == 0, (j % 256) == 255, tag, 8'(j % 256), ~{tag, 8'(j % 256)}};
      compared++;
      if (q_out[j] !== expv) begin
        mismatched++;
        $display("FAIL stall_data[%0d]: got %h want %h", j, q_out[j], expv);
      end
    end
    compared++;
    if (hold_err !== 0 || ovf_cnt !== 0) begin
      mismatched++;
      $display("FAIL stall_hold: got hold changes %0d overflow %0d want 0 0", hold_err, ovf_cnt);
    end
  endtask

  task automatic test_overflow();
    int s, l;
    logic [7:0] tag;
    logic [33:0] expv;
    clear_mon();
    dout_ready = 1'b0;
    send_frame(8'd7, 256, s, l);
    send_frame(8'd8, 256, s, l);
    send_frame(8'd9, 256, s, l);
    idle();
    settle(5);
    compared++;
    if (ovf_cnt !== 1 || ovf_cyc !== s + 1) begin
      mismatched++;
      $display("FAIL ovf_pulse: got count %0d at cycle %0d want 1 at %0d", ovf_cnt, ovf_cyc, s + 1);
    end
    compared++;
    if (q_out.size() !== 0 || dout_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_stalled: got transfers %0d valid %b want 0 1", q_out.size(), dout_valid);
    end
    dout_ready = 1'b1;
    wait_outputs(512, 800);
    settle(300);
    compared++;
    if (q_out.size() !== 512) begin
      mismatched++;
      $display("FAIL ovf_count: got %0d want 512", q_out.size());
    end
    for (int j = 0; j < q_out.size() && j < 512; j++) begin
      tag  = (j < 256) ? 8'd7 : 8'd8;
      expv = {(j % 256) == 0, (j % 256) == 255, tag, 8'(j % 256), ~{tag, 8'(j % 256)}};
      compared++;
      if (q_out[j] !== expv) begin
        mismatched++;
        $display("FAIL ovf_data[%0d]: got %h want %h", j, q_out[j], expv);
      end
    end
  endtask

  task automatic test_sof_err();
    int s, l;
    logic [33:0] expv;
    clear_mon();
    dout_ready = 1'b1;
    send_frame(8'd10, 100, s, l);
    send_frame(8'd11, 256, s, l);
    idle();
    wait_outputs(256, 600);
    settle(300);
    compared++;
    if (serr_cnt !== 1 || serr_cyc !== s + 1) begin
      mismatched++;
      $display("FAIL sof_err_pulse: got count %0d at cycle %0d want 1 at %0d", serr_cnt, serr_cyc, s + 1);
    end
    compared++;
    if (q_out.size() !== 256 || ovf_cnt !== 0) begin
      mismatched++;
      $display("FAIL sof_err_count: got %0d outputs overflow %0d want 256 0", q_out.size(), ovf_cnt);
    end
    for (int j = 0; j < q_out.size() && j < 256; j++) begin
      expv = {j == 0, j == 255, 8'd11, 8'(j), ~{8'd11, 8'(j)}};
      compared++;
      if (q_out[j] !== expv) begin
        mismatched++;
        $display("FAIL sof_err_data[%0d]: got %h want %h", j, q_out[j], expv);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int s, l;
    logic [33:0] expv;
    clear_mon();
    dout_ready = 1'b1;
    send_frame(8'd12, 256, s, l);
    idle();
    wait_outputs(40, 600);
    compared++;
    if (q_out.size() !== 40) begin
      mismatched++;
      $display("FAIL rst_drain_reach: got %0d outputs want 40", q_out.size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({dout_valid, dout_r, dout_i, dout_sof, dout_eof, overflow, sof_err} !== 37'd0) begin
      mismatched++;
      $display("FAIL rst_drain_outputs: got %h want 0",
               {dout_valid, dout_r, dout_i, dout_sof, dout_eof, overflow, sof_err});
    end
    clear_mon();
    send_frame(8'd13, 256, s, l);
    idle();
    wait_outputs(256, 600);
    settle(300);
    compared++;
    if (q_out.size() !== 256) begin
      mismatched++;
      $display("FAIL rst_drain_count: got %0d want 256", q_out.size());
    end
    for (int j = 0; j < q_out.size() && j < 256; j++) begin
      expv = {j == 0, j == 255, 8'd13, 8'(j), ~{8'd13, 8'(j)}};
      compared++;
      if (q_out[j] !== expv) begin
        mismatched++;
        $display("FAIL rst_drain_data[%0d]: got %h want %h", j, q_out[j], expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_sof_err();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
